// File: rtl/enigma_uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// enigma_tx_pkg
// Shared definitions for the Enigma ciphertext UART transmitter:
//   - tx_state_t     : serializer FSM states
//   - ASCII_*        : byte values placed on the line
//   - GROUP_LEN      : letters per cipher group (used when ENIGMA_TX_GROUP_EN
//                      is defined)
//   - encode_letter(): 5-bit letter code -> ASCII byte
// ----------------------------------------------------------------------------
package enigma_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam int unsigned GROUP_LEN = 5;

    // Codes 0..25 are A..Z; anything above is not a letter and shows as '?'.
    function automatic logic [7:0] encode_letter(input logic [4:0] code);
        logic [7:0] ch;
        if (code < 5'd26) begin
            ch = ASCII_A + {3'b000, code};
        end else begin
            ch = ASCII_QMARK;
        end
        return ch;
    endfunction

endpackage

// File: rtl/enigma_uart_tx_if.sv
// ----------------------------------------------------------------------------
// enigma_uart_tx_if
// Letter input handshake plus UART/status outputs of enigma_uart_tx.
//   letter_valid_in : one-cycle pulse, char_in valid
//   char_in[4:0]    : letter code, 0..25 = A..Z
//   tx_out          : UART serial line, idle high
//   busy_out        : transmitter active or letters pending
//   full_out        : letter FIFO full
//   drop_out        : one-cycle pulse, a letter was discarded
// Modports: master = letter source / line observer, slave = transmitter.
// ----------------------------------------------------------------------------
interface enigma_uart_tx_if;

    logic       letter_valid_in;
    logic [4:0] char_in;
    logic       tx_out;
    logic       busy_out;
    logic       full_out;
    logic       drop_out;

    modport master (
        output letter_valid_in,
        output char_in,
        input  tx_out,
        input  busy_out,
        input  full_out,
        input  drop_out
    );

    modport slave (
        input  letter_valid_in,
        input  char_in,
        output tx_out,
        output busy_out,
        output full_out,
        output drop_out
    );

endinterface

// File: rtl/enigma_uart_tx_letter_fifo.sv
// ----------------------------------------------------------------------------
// letter_fifo
// Synchronous first-word-fall-through FIFO holding encoded letter bytes.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   wr_en, wr_data   : write request (ignored while full)
//   rd_en, rd_data   : pop request (ignored while empty); rd_data is the head
//   full, empty      : registered status flags
//   count_next       : occupancy after this cycle's write/pop
// DEPTH must be a power of two, >= 2.
// ----------------------------------------------------------------------------
module letter_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count_next
);
    import enigma_tx_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wr_fire, rd_fire;

    assign wr_fire = wr_en && !full_q;
    assign rd_fire = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_in) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data    = mem_q[rd_ptr_q];
    assign full       = full_q;
    assign empty      = empty_q;
    assign count_next = count_d;

endmodule

// File: rtl/enigma_uart_tx.sv
// ----------------------------------------------------------------------------
// enigma_uart_tx
// Buffers the Enigma core's 5-bit ciphertext letters, converts them to ASCII
// and sends each as an 8N1 UART frame (LSB first) on tx_out.
//   clk_in   : system clock, all state on rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : enigma_uart_tx_if.slave
//              letter_valid_in/char_in in; tx_out, busy_out, full_out,
//              drop_out out
// Parameters: CLK_HZ, BAUD (BAUD_DIV = CLK_HZ/BAUD >= 2), FIFO_DEPTH (pow2).
// Optional feature macro ENIGMA_TX_GROUP_EN: inserts a space frame after
// every GROUP_LEN letters (five-letter cipher groups).
// ----------------------------------------------------------------------------
module enigma_uart_tx #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    enigma_uart_tx_if.slave    bus
);
    import enigma_tx_pkg::*;

    localparam int unsigned BAUD_DIV = CLK_HZ / BAUD;
    localparam int unsigned TMR_W    = $clog2(BAUD_DIV);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BAUD_DIV - 1);
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;

    tx_state_t        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             drop_q, drop_d;
`ifdef ENIGMA_TX_GROUP_EN
    logic [2:0]       grp_q, grp_d;
    logic             space_q, space_d;
`endif

    logic             fifo_wr;
    logic             fifo_rd;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count_next;
    logic             bit_end;

    // The registered full flag gates the write, so a write arriving while
    // full is dropped even if the FSM pops in the same cycle.
    assign fifo_wr = bus.letter_valid_in && !fifo_full;

    letter_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .wr_en      (fifo_wr),
        .wr_data    (encode_letter(bus.char_in)),
        .rd_en      (fifo_rd),
        .rd_data    (fifo_rd_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count_next (fifo_count_next)
    );

    assign bit_end = (timer_q == TMR_LAST);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_rd   = 1'b0;
`ifdef ENIGMA_TX_GROUP_EN
        grp_d     = grp_q;
        space_d   = space_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = START;
`ifdef ENIGMA_TX_GROUP_EN
                    // A full group goes out as a space first; the pending
                    // letter stays at the FIFO head for the next IDLE.
                    if (grp_q == 3'(GROUP_LEN)) begin
                        shift_d = ASCII_SPACE;
                        space_d = 1'b1;
                        grp_d   = '0;
                    end else begin
                        shift_d = fifo_rd_data;
                        fifo_rd = 1'b1;
                        space_d = 1'b0;
                    end
`else
                    shift_d = fifo_rd_data;
                    fifo_rd = 1'b1;
`endif
                end
            end
            START: begin
                timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
                if (bit_end) begin
                    state_d = IDLE;
`ifdef ENIGMA_TX_GROUP_EN
                    if (!space_q) begin
                        grp_d = grp_q + 3'd1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || (fifo_count_next != '0);
        drop_d = bus.letter_valid_in && fifo_full;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
`ifdef ENIGMA_TX_GROUP_EN
            grp_q     <= '0;
            space_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
`ifdef ENIGMA_TX_GROUP_EN
            grp_q     <= grp_d;
            space_q   <= space_d;
`endif
        end
    end

    always_comb begin
        unique case (state_q)
            START:   bus.tx_out = 1'b0;
            DATA:    bus.tx_out = shift_q[0];
            default: bus.tx_out = 1'b1;
        endcase
    end

    assign bus.busy_out = busy_q;
    assign bus.full_out = fifo_full;
    assign bus.drop_out = drop_q;

endmodule
